// File: rtl/rom_string_reader.sv
// rom_string_reader
// Read-side initiator for a small synchronous message ROM. On start it walks
// ROM addresses from START_ADDR and streams every non-zero byte to a UART
// transmitter over a valid/ready handshake. The walk ends at the first 0x00
// byte or after the last address; addresses never wrap.
//
// Optional feature (compile-time): APPEND_CRLF_EN
//   When defined, every message is followed by 0x0D then 0x0A, sent with the
//   same valid/ready rules as payload bytes, before done_o pulses.
//   When undefined, the CR and LF states do not exist and the message ends
//   directly in IDLE.
//
// Timing with tx_ready_i held high:
//   start edge -> FETCH -> LOAD -> SEND (tx_valid_o high), so the first byte
//   is offered 2 cycles after the start edge. Each subsequent byte follows
//   3 cycles later (SEND -> FETCH -> LOAD -> SEND).

module rom_string_reader #(
    parameter int                ADDR_W     = 4,
    parameter int                DATA_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    // ------------------------------------------------------------------
    // State encoding. CR/LF only exist when the trailer is enabled.
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SEND  = 3'd3
`ifdef APPEND_CRLF_EN
        ,
        ST_CR    = 3'd4,
        ST_LF    = 3'd5
`endif
    } state_t;

`ifdef APPEND_CRLF_EN
    localparam logic [DATA_W-1:0] CR_BYTE = DATA_W'(8'h0D);
    localparam logic [DATA_W-1:0] LF_BYTE = DATA_W'(8'h0A);
`endif

    state_t state_r;

    // ------------------------------------------------------------------
    // Helper predicates
    // ------------------------------------------------------------------

    // A 0x00 byte marks the end of the stored string.
    function automatic logic is_terminator(input logic [DATA_W-1:0] data);
        return (data == {DATA_W{1'b0}});
    endfunction

    // The last ROM address ends the walk even without a 0x00 byte.
    function automatic logic is_last_addr(input logic [ADDR_W-1:0] addr);
        return (&addr);
    endfunction

    // Next sequential address; only used when the current one is not last.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
        return addr + ADDR_W'(1'b1);
    endfunction

    // ------------------------------------------------------------------
    // Main controller: state, ROM address and all handshake outputs are
    // registered here so every output is glitch-free.
    // ------------------------------------------------------------------

    // Sequence ROM reads and the TX handshake; done_o is a one-cycle pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            mem_addr_o <= START_ADDR;
            tx_data_o  <= {DATA_W{1'b0}};
            tx_valid_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            // done_o is only ever high for the single cycle after completion
            done_o <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    mem_addr_o <= START_ADDR;
                    tx_valid_o <= 1'b0;
                    if (start_i) begin
                        busy_o  <= 1'b1;
                        state_r <= ST_FETCH;
                    end else begin
                        busy_o  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end

                // The ROM captures mem_addr_o on this edge; data is ready in LOAD.
                ST_FETCH: begin
                    state_r <= ST_LOAD;
                end

                ST_LOAD: begin
                    if (is_terminator(mem_data_i)) begin
`ifdef APPEND_CRLF_EN
                        tx_data_o  <= CR_BYTE;
                        tx_valid_o <= 1'b1;
                        state_r    <= ST_CR;
`else
                        tx_valid_o <= 1'b0;
                        busy_o     <= 1'b0;
                        done_o     <= 1'b1;
                        mem_addr_o <= START_ADDR;
                        state_r    <= ST_IDLE;
`endif
                    end else begin
                        tx_data_o  <= mem_data_i;
                        tx_valid_o <= 1'b1;
                        state_r    <= ST_SEND;
                    end
                end

                // Hold the byte stable until the transmitter takes it.
                ST_SEND: begin
                    if (tx_ready_i) begin
                        if (is_last_addr(mem_addr_o)) begin
`ifdef APPEND_CRLF_EN
                            tx_data_o  <= CR_BYTE;
                            tx_valid_o <= 1'b1;
                            state_r    <= ST_CR;
`else
                            tx_valid_o <= 1'b0;
                            busy_o     <= 1'b0;
                            done_o     <= 1'b1;
                            mem_addr_o <= START_ADDR;
                            state_r    <= ST_IDLE;
`endif
                        end else begin
                            tx_valid_o <= 1'b0;
                            mem_addr_o <= next_addr(mem_addr_o);
                            state_r    <= ST_FETCH;
                        end
                    end else begin
                        state_r <= ST_SEND;
                    end
                end

`ifdef APPEND_CRLF_EN
                // Carriage return offered; line feed follows once accepted.
                ST_CR: begin
                    if (tx_ready_i) begin
                        tx_data_o  <= LF_BYTE;
                        tx_valid_o <= 1'b1;
                        state_r    <= ST_LF;
                    end else begin
                        state_r <= ST_CR;
                    end
                end

                // Line feed offered; message completes once accepted.
                ST_LF: begin
                    if (tx_ready_i) begin
                        tx_valid_o <= 1'b0;
                        busy_o     <= 1'b0;
                        done_o     <= 1'b1;
                        mem_addr_o <= START_ADDR;
                        state_r    <= ST_IDLE;
                    end else begin
                        state_r <= ST_LF;
                    end
                end
`endif

                // Unreachable encodings recover to a quiet IDLE.
                default: begin
                    state_r    <= ST_IDLE;
                    mem_addr_o <= START_ADDR;
                    tx_valid_o <= 1'b0;
                    busy_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_string_reader.sv
// tb_rom_string_reader
// Scoreboard bench for rom_string_reader. Stimulus pushes the expected byte
// stream (and, where meaningful, the expected cycle gap to the previous
// event) into a queue; a monitor pops and compares every accepted byte.
// Honours APPEND_CRLF_EN to expect the 0x0D 0x0A trailer.

module tb_rom_string_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;

    rom_string_reader #(.ADDR_W(4), .DATA_W(8), .START_ADDR(4'h0)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .mem_addr_o (mem_addr),
        .mem_data_i (mem_data),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    // 16x8 synchronous ROM model
    logic [7:0] rom [16];
    always @(posedge clk) mem_data <= rom[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         gap;   // expected cycles since previous event, 0 = unchecked
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   last_ref = 0;
    int   start_cyc = 0;
    int   done_cnt = 0;
    int   exp_done = 0;
    int   last_done_cyc = 0;

    // "Simple UART EyC" hand-coded
    logic [7:0] msg [15] = '{8'h53, 8'h69, 8'h6D, 8'h70, 8'h6C, 8'h65, 8'h20, 8'h55,
                             8'h41, 8'h52, 8'h54, 8'h20, 8'h45, 8'h79, 8'h43};

`ifdef APPEND_CRLF_EN
    localparam int EMPTY_DONE_LAT = 4;
`else
    localparam int EMPTY_DONE_LAT = 2;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input logic [7:0] d, input int g);
        exp_t e;
        e.data = d;
        e.gap  = g;
        sb.push_back(e);
    endtask

    task automatic push_trailer();
`ifdef APPEND_CRLF_EN
        push(8'h0D, 0);
        push(8'h0A, 0);
`endif
    endtask

    task automatic load_msg();
        string s;
        s = "Simple UART EyC";
        for (int i = 0; i < 15; i++) rom[i] = s[i];
        rom[15] = 8'h00;
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
        last_ref  = cyc;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done_cnt < exp_done && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check("done_count", done_cnt, exp_done);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: pop and compare every byte accepted, count done pulses.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tx_valid && tx_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no byte (cycle %0d)", tx_data, cyc);
                    end else begin
                        e = sb.pop_front();
                        check("tx_byte", {24'h0, tx_data}, {24'h0, e.data});
                        if (e.gap != 0) check("byte_gap", cyc - last_ref, e.gap);
                        last_ref = cyc;
                    end
                end
                if (done) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                    check("queue_empty_at_done", sb.size(), 0);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        rst = 1'b1;
        start = 1'b0;
        tx_ready = 1'b1;
        load_msg();
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(1);

        // Reset state
        check("rst_addr",  {28'h0, mem_addr}, 32'h0);
        check("rst_data",  {24'h0, tx_data},  32'h0);
        check("rst_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_busy",  {31'h0, busy},     32'h0);
        check("rst_done",  {31'h0, done},     32'h0);

        // 1: full message, ready high, 2/3-cycle spacing
        for (int i = 0; i < 15; i++) push(msg[i], (i == 0) ? 2 : 3);
        push_trailer();
        exp_done++;
        do_start();
        check("busy_after_start", {31'h0, busy}, 32'h1);
        wait_done(200);
        check("addr_after_done", {28'h0, mem_addr}, 32'h0);
        check("busy_after_done", {31'h0, busy}, 32'h0);
        idle_cycles(5);
        check("single_done_t1", done_cnt, exp_done);

        // 2: stall on "m" for 5 cycles
        for (int i = 0; i < 15; i++) push(msg[i], 0);
        push_trailer();
        exp_done++;
        do_start();
        k = 0;
        while (!(tx_valid && tx_data == 8'h69) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("saw_byte_i", {31'h0, tx_valid}, 32'h1);
        @(posedge clk); #1;           // 'i' accepted on that edge
        tx_ready = 1'b0;
        k = 0;
        while (!tx_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'h0, tx_valid}, 32'h1);
            check("stall_data",  {24'h0, tx_data},  32'h6D);
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        wait_done(200);
        idle_cycles(3);

        // 3: empty string
        rom[0] = 8'h00;
`ifdef APPEND_CRLF_EN
        push(8'h0D, 2);
        push(8'h0A, 1);
`endif
        exp_done++;
        do_start();
        wait_done(50);
        check("empty_done_latency", last_done_cyc - start_cyc, EMPTY_DONE_LAT);
        idle_cycles(3);

        // 4: no terminator, all 16 addresses
        for (int i = 0; i < 16; i++) begin
            rom[i] = 8'h41 + 8'(i);
            push(8'h41 + 8'(i), (i == 0) ? 2 : 3);
        end
        push_trailer();
        exp_done++;
        do_start();
        wait_done(200);
        check("addr_after_exhaust", {28'h0, mem_addr}, 32'h0);
        idle_cycles(3);

        // 5a: extra start mid-message is ignored
        load_msg();
        for (int i = 0; i < 15; i++) push(msg[i], 0);
        push_trailer();
        exp_done++;
        do_start();
        idle_cycles(10);
        start = 1'b1;
        idle_cycles(1);
        start = 1'b0;
        wait_done(200);
        idle_cycles(8);
        check("no_restart", done_cnt, exp_done);
        check("idle_after_5a", {31'h0, busy}, 32'h0);

        // 5b: reset during SEND aborts
        tx_ready = 1'b0;
        push(msg[0], 0);
        do_start();
        k = 0;
        while (!tx_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("in_send", {31'h0, tx_valid}, 32'h1);
        rst = 1'b1;
        #1;
        sb.delete();
        check("abort_valid", {31'h0, tx_valid}, 32'h0);
        check("abort_data",  {24'h0, tx_data},  32'h0);
        check("abort_busy",  {31'h0, busy},     32'h0);
        check("abort_addr",  {28'h0, mem_addr}, 32'h0);
        idle_cycles(2);
        rst = 1'b0;
        tx_ready = 1'b1;
        idle_cycles(10);
        check("no_done_after_abort", done_cnt, exp_done);
        check("quiet_after_abort", {31'h0, tx_valid}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
